// File: rtl/tetris_pkg.sv
// rtl/tetris_pkg.sv - shared state encoding and sizing for the row-clear controller
package tetris_pkg;

    localparam int DEF_ROWS      = 8;
    localparam int DEF_COLS      = 8;
    localparam int SETTLE_CNT_W  = 4;
    localparam int LAND_CNT_MAX  = 7;
    localparam int LINES_MAX     = 255;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DESTRUCT,
        ST_SETTLE,
        ST_SPAWN,
        ST_OVER
    } state_t;

endpackage

// File: rtl/row_full_detect.sv
// rtl/row_full_detect.sv - full-row detection with lowest-index priority select
module row_full_detect
    import tetris_pkg::*;
#(
    parameter int ROWS  = DEF_ROWS,
    parameter int COLS  = DEF_COLS,
    parameter int IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic [ROWS*COLS-1:0] fixed,
    output logic                 any_full,
    output logic [IDX_W-1:0]     idx
);

    logic [ROWS-1:0] full;

    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            full[r] = &fixed[r*COLS +: COLS];
        end
    end

    // Walk top-down so the last assignment is the lowest full row.
    always_comb begin
        idx = '0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (full[r]) begin
                idx = IDX_W'(r);
            end
        end
    end

    assign any_full = |full;

endmodule

// File: rtl/row_clear_ctrl.sv
// rtl/row_clear_ctrl.sv - clears full matrix rows one at a time after each landing
module row_clear_ctrl
    import tetris_pkg::*;
#(
    parameter int ROWS          = DEF_ROWS,
    parameter int COLS          = DEF_COLS,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ROWS*COLS-1:0] fixed,
    input  logic                 landed_done,
    input  logic                 spawn_ack,
    output logic [ROWS-1:0]      destruct,
    output logic                 spawn_req,
    output logic                 busy,
    output logic                 game_over,
    output logic [7:0]           lines_cleared,
    output logic [2:0]           last_clear
);

    localparam int IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [SETTLE_CNT_W-1:0] SETTLE_LAST = SETTLE_CNT_W'(SETTLE_CYCLES - 1);

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        target_q, target_d;
    logic [SETTLE_CNT_W-1:0] settle_cnt_q, settle_cnt_d;
    logic [2:0]              land_cnt_q, land_cnt_d;
    logic [2:0]              last_clear_q, last_clear_d;
    logic [7:0]              lines_q, lines_d;
    logic [ROWS-1:0]         destruct_q, destruct_d;
    logic                    spawn_req_q, spawn_req_d;
    logic                    busy_q, busy_d;
    logic                    game_over_q, game_over_d;

    logic                    any_full;
    logic [IDX_W-1:0]        full_idx;
    logic                    top_occupied;

    row_full_detect #(
        .ROWS  (ROWS),
        .COLS  (COLS),
        .IDX_W (IDX_W)
    ) u_detect (
        .fixed    (fixed),
        .any_full (any_full),
        .idx      (full_idx)
    );

    assign top_occupied = |fixed[(ROWS-1)*COLS +: COLS];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (landed_done) state_d = ST_SCAN;
            ST_SCAN: begin
                if (any_full)          state_d = ST_DESTRUCT;
                else if (top_occupied) state_d = ST_OVER;
                else                   state_d = ST_SPAWN;
            end
            ST_DESTRUCT: state_d = ST_SETTLE;
            ST_SETTLE:   if (settle_cnt_q == SETTLE_LAST) state_d = ST_SCAN;
            ST_SPAWN:    if (spawn_ack) state_d = ST_IDLE;
            ST_OVER:     state_d = ST_OVER;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Counters and target only move on the transitions that own them.
    always_comb begin
        target_d     = target_q;
        settle_cnt_d = '0;
        land_cnt_d   = land_cnt_q;
        last_clear_d = last_clear_q;
        lines_d      = lines_q;
        if (state_q == ST_SCAN && any_full) begin
            target_d = full_idx;
        end
        if (state_q == ST_SETTLE && settle_cnt_q != SETTLE_LAST) begin
            settle_cnt_d = settle_cnt_q + SETTLE_CNT_W'(1);
        end
        if (state_q == ST_DESTRUCT) begin
            if (lines_q != 8'(LINES_MAX))    lines_d    = lines_q + 8'd1;
            if (land_cnt_q != 3'(LAND_CNT_MAX)) land_cnt_d = land_cnt_q + 3'd1;
        end
        if (state_q == ST_SCAN && state_d == ST_SPAWN) begin
            last_clear_d = land_cnt_q;
            land_cnt_d   = '0;
        end
    end

    // Outputs decoded from the next state so they come straight off flops.
    always_comb begin
        destruct_d  = '0;
        spawn_req_d = (state_d == ST_SPAWN);
        busy_d      = (state_d != ST_IDLE);
        game_over_d = (state_d == ST_OVER);
        for (int i = 0; i < ROWS; i++) begin
            destruct_d[i] = (state_d == ST_DESTRUCT) && (i >= int'(target_d));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            target_q     <= '0;
            settle_cnt_q <= '0;
            land_cnt_q   <= '0;
            last_clear_q <= '0;
            lines_q      <= '0;
            destruct_q   <= '0;
            spawn_req_q  <= 1'b0;
            busy_q       <= 1'b0;
            game_over_q  <= 1'b0;
        end else begin
            target_q     <= target_d;
            settle_cnt_q <= settle_cnt_d;
            land_cnt_q   <= land_cnt_d;
            last_clear_q <= last_clear_d;
            lines_q      <= lines_d;
            destruct_q   <= destruct_d;
            spawn_req_q  <= spawn_req_d;
            busy_q       <= busy_d;
            game_over_q  <= game_over_d;
        end
    end

    assign destruct      = destruct_q;
    assign spawn_req     = spawn_req_q;
    assign busy          = busy_q;
    assign game_over     = game_over_q;
    assign lines_cleared = lines_q;
    assign last_clear    = last_clear_q;

endmodule

// File: doc/row_clear_ctrl.md
ROW_CLEAR_CTRL -- requirements
Module: row_clear_ctrl

Interface
REQ-001 The module SHALL have parameter ROWS, default 8, meaning the number of matrix rows; row 0 is the bottom row.
REQ-002 The module SHALL have parameter COLS, default 8, meaning the number of matrix columns.
REQ-003 The module SHALL have parameter SETTLE_CYCLES, default 1, range 1..15, meaning the wait cycles after each destruct before rescanning.
REQ-004 clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-006 fixed  input  ROWS*COLS  fixed bit of every LED cell, bit index r*COLS+c.
REQ-007 landed_done  input  1  one-cycle pulse from the tetrimino driver after the active piece has been fixed.
REQ-008 spawn_ack  input  1  tetrimino driver accepts the spawn request.
REQ-009 destruct  output  ROWS  per-row destruct strobe to the LED drivers.
REQ-010 spawn_req  output  1  request a new active piece.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 game_over  output  1  sticky end-of-game flag.
REQ-013 lines_cleared  output  8  total rows cleared since reset, saturating.
REQ-014 last_clear  output  3  rows cleared by the most recent landing.

Function
REQ-015 The FSM SHALL have exactly six states: IDLE, SCAN, DESTRUCT, SETTLE, SPAWN, OVER.
REQ-016 IDLE SHALL go to SCAN on the cycle after landed_done=1; landed_done SHALL be ignored in every other state.
REQ-017 SCAN SHALL compute full[r]=&fixed[r*COLS +: COLS] and select the lowest r with full[r]=1.
REQ-018 SCAN, when any row is full, SHALL register that row index into target and go to DESTRUCT next cycle.
REQ-019 SCAN, when no row is full and any bit of row ROWS-1 is set, SHALL go to OVER.
REQ-020 SCAN, when no row is full and row ROWS-1 is empty, SHALL go to SPAWN.
REQ-021 DESTRUCT SHALL last exactly one cycle, driving destruct[i]=1 for every i>=target and 0 below.
REQ-022 DESTRUCT SHALL increment lines_cleared unless it is already 255, and increment the per-landing counter.
REQ-023 DESTRUCT SHALL then go to SETTLE.
REQ-024 SETTLE SHALL hold destruct=0 for SETTLE_CYCLES cycles via a 4-bit counter, then return to SCAN.
REQ-025 Multiple full rows SHALL therefore be cleared one per DESTRUCT/SETTLE/SCAN loop, lowest first.
REQ-026 On entry to SPAWN, last_clear SHALL load the per-landing counter, and that counter SHALL clear.
REQ-027 spawn_req SHALL be 1 throughout SPAWN.
REQ-028 SPAWN SHALL go to IDLE on the cycle after spawn_ack=1; spawn_ack seen in the entry cycle SHALL count.
REQ-029 spawn_ack outside SPAWN SHALL be ignored.
REQ-030 OVER SHALL be terminal until reset, with game_over=1 and spawn_req=0.
REQ-031 destruct, spawn_req, busy and game_over SHALL be registered outputs that never glitch.
REQ-032 The per-landing counter SHALL saturate at 7.
REQ-033 fixed SHALL be sampled only in SCAN; changes to fixed during SETTLE SHALL be expected and tolerated.

Reset
REQ-034 reset=0 SHALL immediately force state IDLE, destruct=0, spawn_req=0, busy=0, game_over=0, lines_cleared=0, last_clear=0, target=0, and both counters to 0.
REQ-035 Reset asserted mid-DESTRUCT SHALL drop destruct asynchronously within the same cycle.
REQ-036 Deassertion SHALL resume in IDLE, waiting for landed_done.

Structure
REQ-037 The state enum, ROWS/COLS defaults and the SETTLE counter width SHALL live in shared package tetris_pkg.
REQ-038 The full-row detection plus lowest-index priority encoder SHALL be sub-module row_full_detect, with outputs any_full and idx.
REQ-039 The RTL SHALL fit in 120-400 lines.

Verification
REQ-040 Single clear: fixed row 0 = 8'hFF, other rows 0, landed_done pulse -> SCAN, then destruct=8'hFF for 1 cycle, SETTLE 1 cycle, then spawn_req=1, last_clear=1, lines_cleared=1.
REQ-041 Double clear: rows 2 and 5 full; model shifts rows down on destruct -> destruct=8'hFC, then (row 5 now row 4) 8'hF0; last_clear=2.
REQ-042 No clear: row 0 = 8'h7F, landed_done -> no destruct, spawn_req within 2 cycles; spawn_ack held 3 cycles later -> IDLE, busy=0.
REQ-043 Top-out: row 7 = 8'h01 with no full rows, landed_done -> game_over=1 stays set; further landed_done and spawn_ack have no effect.
REQ-044 Saturation: 260 single-row clears -> lines_cleared=255.
REQ-045 Reset mid-operation: reset=0 during DESTRUCT -> destruct=0 before the next edge; state IDLE; landed_done pulse during SETTLE ignored.
